// File: rtl/fetch_pc_unit.sv
// -----------------------------------------------------------------------------
// fetch_pc_unit
//   Instruction-fetch / program-counter stage sitting in front of the opcode
//   decoder. Holds the PC and fetches one instruction word at a time over a
//   req/ack handshake. It presents opcode/funct to the decoder and forms the
//   next PC from the decoder's jump/branch results when the instruction retires.
//
// Parameters
//   RESET_PC        PC loaded on reset
//   TIMEOUT_CYCLES  FETCH cycles without ack before fetch_err (0 = disabled)
//
// Build option
//   PC_ALIGN_CHK_EN  defined   : a misaligned next PC traps into the error
//                                state with the faulting address left in pc.
//                    undefined : next_pc[1:0] is silently forced to 2'b00.
//
// Ports
//   clk, rst_n            clock (rising edge), synchronous active-low reset
//   imem_req/imem_addr    fetch request and address (= pc)
//   imem_ack/imem_rdata   memory response
//   instr, instr_valid    latched instruction and its valid flag
//   opcode, funct         instr[31:26], instr[5:0] for the decoder
//   pc, pc_plus4          address of instr and its sequential successor
//   retire, stall         downstream completion handshake
//   jump, branch,
//   branch_taken, rs_val  redirect information, valid on the retire cycle
//   fetch_err             sticky fetch timeout / misalignment error
// -----------------------------------------------------------------------------
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        retire,
  input  logic        stall,
  input  logic [1:0]  jump,
  input  logic        branch,
  input  logic        branch_taken,
  input  logic [31:0] rs_val,
  output logic        fetch_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_ERR   = 2'd3;

  // Counter only needs to reach TIMEOUT_CYCLES-1.
  localparam int unsigned     CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam bit               TO_EN    = (TIMEOUT_CYCLES != 0);

  logic [1:0]       state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic [31:0]        pc_plus4_w;
  logic [31:0]        jump_tgt;
  logic signed [31:0] br_off;
  logic [31:0]        next_pc;
  logic               retire_go;

  assign pc_plus4_w = pc_q + 32'd4;
  assign jump_tgt   = {pc_plus4_w[31:28], instr_q[25:0], 2'b00};
  assign br_off     = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
  assign retire_go  = retire && !stall;

  // Redirect priority: J/JAL, then JR, then taken branch, else sequential.
  // jump==2'b11 falls into the sequential/branch path.
  always_comb begin
    next_pc = pc_plus4_w;
    case (jump)
      2'b01:   next_pc = jump_tgt;
      2'b10:   next_pc = rs_val;
      default: begin
        if (branch && branch_taken) begin
          next_pc = pc_plus4_w + $unsigned(br_off);
        end
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          cnt_d   = '0;
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (TO_EN && (cnt_q == CNT_LAST)) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (retire_go) begin
`ifdef PC_ALIGN_CHK_EN
          // Faulting address stays visible in pc for diagnosis.
          pc_d = next_pc;
          if (next_pc[1:0] != 2'b00) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else begin
            state_d = S_FETCH;
          end
`else
          pc_d    = {next_pc[31:2], 2'b00};
          state_d = S_FETCH;
`endif
        end
      end
      default: begin
        // S_ERR is left only through reset.
        state_d = S_ERR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign imem_req    = (state_q == S_FETCH);
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = (state_q == S_HOLD);
  assign opcode      = instr_q[31:26];
  assign funct       = instr_q[5:0];
  assign pc          = pc_q;
  assign pc_plus4    = pc_plus4_w;
  assign fetch_err   = err_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        retire;
  logic        stall;
  logic [1:0]  jump;
  logic        branch;
  logic        branch_taken;
  logic [31:0] rs_val;
  logic        fetch_err;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  fetch_pc_unit #(
    .RESET_PC      (32'h0000_0000),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .opcode      (opcode),
    .funct       (funct),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .retire      (retire),
    .stall       (stall),
    .jump        (jump),
    .branch      (branch),
    .branch_taken(branch_taken),
    .rs_val      (rs_val),
    .fetch_err   (fetch_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a request, check address, answer after 'delay' cycles.
  task automatic fetch(input string tag, input logic [31:0] addr,
                       input logic [31:0] word, input int delay);
    int w = 0;
    while (imem_req !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    chk({tag, "_req"}, {31'd0, imem_req}, 32'd1);
    chk({tag, "_addr"}, imem_addr, addr);
    for (int i = 0; i < delay; i++) begin
      tick();
      chk({tag, "_wait_req"}, {31'd0, imem_req}, 32'd1);
      chk({tag, "_wait_vld"}, {31'd0, instr_valid}, 32'd0);
    end
    imem_ack   = 1'b1;
    imem_rdata = word;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    chk({tag, "_vld"}, {31'd0, instr_valid}, 32'd1);
    chk({tag, "_instr"}, instr, word);
    chk({tag, "_pc"}, pc, addr);
  endtask

  task automatic retire_op(input logic [1:0] j, input logic br, input logic tk,
                           input logic [31:0] rs);
    jump         = j;
    branch       = br;
    branch_taken = tk;
    rs_val       = rs;
    retire       = 1'b1;
    tick();
    retire       = 1'b0;
    jump         = 2'b00;
    branch       = 1'b0;
    branch_taken = 1'b0;
    rs_val       = 32'd0;
  endtask

  initial begin
    rst_n        = 1'b0;
    imem_ack     = 1'b0;
    imem_rdata   = 32'd0;
    retire       = 1'b0;
    stall        = 1'b0;
    jump         = 2'b00;
    branch       = 1'b0;
    branch_taken = 1'b0;
    rs_val       = 32'd0;
    tick();
    tick();

    // Reset state
    chk("rst_req",   {31'd0, imem_req},    32'd0);
    chk("rst_vld",   {31'd0, instr_valid}, 32'd0);
    chk("rst_pc",    pc,                   32'h0);
    chk("rst_err",   {31'd0, fetch_err},   32'd0);
    chk("rst_instr", instr,                32'd0);

    // Release: one IDLE cycle, then fetch from RESET_PC, ack one cycle late
    rst_n = 1'b1;
    chk("idle_req", {31'd0, imem_req}, 32'd0);
    tick();
    fetch("addi", 32'h0, 32'h2008_0005, 1);
    chk("addi_opcode", {26'd0, opcode}, 32'h08);
    chk("addi_funct",  {26'd0, funct},  32'h05);
    chk("addi_pc4",    pc_plus4,        32'h4);
    retire_op(2'b00, 1'b0, 1'b0, 32'd0);
    chk("seq_pc",  pc,                     32'h4);
    chk("seq_req", {31'd0, imem_req},      32'd1);
    chk("seq_vld", {31'd0, instr_valid},   32'd0);

    // JR to 0x40, BEQ taken -> 0x3C
    fetch("w1", 32'h4, 32'h0000_0008, 0);
    retire_op(2'b10, 1'b0, 1'b0, 32'h40);
    chk("jr_pc", pc, 32'h40);
    fetch("beq", 32'h40, 32'h1000_FFFE, 0);
    retire_op(2'b00, 1'b1, 1'b1, 32'd0);
    chk("beq_taken_pc", pc, 32'h3C);

    // Back to 0x40, BEQ not taken -> 0x44
    fetch("w2", 32'h3C, 32'h0000_0008, 0);
    retire_op(2'b10, 1'b0, 1'b0, 32'h40);
    fetch("beq2", 32'h40, 32'h1000_FFFE, 0);
    retire_op(2'b00, 1'b1, 1'b0, 32'd0);
    chk("beq_ntaken_pc", pc, 32'h44);

    // jump=11 behaves like 00, so the taken branch applies: 0x48 - 8 = 0x40
    fetch("beq3", 32'h44, 32'h1000_FFFE, 0);
    retire_op(2'b11, 1'b1, 1'b1, 32'h999);
    chk("j11_pc", pc, 32'h40);

    // JAL from 0x8000_0010
    fetch("w3", 32'h40, 32'h0000_0008, 0);
    retire_op(2'b10, 1'b0, 1'b0, 32'h8000_0010);
    fetch("jal", 32'h8000_0010, 32'h0C00_0100, 0);
    chk("jal_pc4", pc_plus4, 32'h8000_0014);
    retire_op(2'b01, 1'b0, 1'b0, 32'd0);
    chk("jal_pc", pc, 32'h8000_0400);

    // Stalled retire for 3 cycles; stray ack in HOLD must be ignored
    fetch("stl", 32'h8000_0400, 32'hA5A5_5A5A, 0);
    stall      = 1'b1;
    retire     = 1'b1;
    jump       = 2'b10;
    rs_val     = 32'h100;
    imem_ack   = 1'b1;
    imem_rdata = 32'h1111_2222;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_vld",   {31'd0, instr_valid}, 32'd1);
      chk("stall_pc",    pc,                   32'h8000_0400);
      chk("stall_instr", instr,                32'hA5A5_5A5A);
    end
    stall    = 1'b0;
    retire   = 1'b0;
    imem_ack = 1'b0;
    retire_op(2'b10, 1'b0, 1'b0, 32'hFFFF_FFFC);
    chk("top_pc", pc, 32'hFFFF_FFFC);

    // Wrap-around of pc+4
    fetch("wrap", 32'hFFFF_FFFC, 32'h0000_0000, 0);
    chk("wrap_pc4", pc_plus4, 32'h0);
    retire_op(2'b00, 1'b0, 1'b0, 32'd0);
    chk("wrap_pc", pc, 32'h0);

    // Misaligned JR target
    fetch("mis", 32'h0, 32'h0000_0008, 0);
    retire_op(2'b10, 1'b0, 1'b0, 32'h1236);
`ifdef PC_ALIGN_CHK_EN
    chk("mis_err", {31'd0, fetch_err}, 32'd1);
    chk("mis_pc",  pc,                 32'h1236);
    chk("mis_req", {31'd0, imem_req},  32'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
`else
    chk("mis_err",  {31'd0, fetch_err}, 32'd0);
    chk("mis_pc",   pc,                 32'h1234);
    chk("mis_req",  {31'd0, imem_req},  32'd1);
    chk("mis_addr", imem_addr,          32'h1234);
`endif

    // Near-miss timeout: ack on the 16th FETCH cycle
    for (int i = 0; i < 15; i++) tick();
    chk("nm_req", {31'd0, imem_req}, 32'd1);
    imem_ack   = 1'b1;
    imem_rdata = 32'h0000_0008;
    tick();
    imem_ack   = 1'b0;
    chk("nm_vld", {31'd0, instr_valid}, 32'd1);
    chk("nm_err", {31'd0, fetch_err},   32'd0);
    retire_op(2'b00, 1'b0, 1'b0, 32'd0);

    // Real timeout: 16 FETCH cycles without ack
    for (int i = 0; i < 15; i++) tick();
    chk("to_pre_req", {31'd0, imem_req},  32'd1);
    chk("to_pre_err", {31'd0, fetch_err}, 32'd0);
    tick();
    chk("to_err", {31'd0, fetch_err},   32'd1);
    chk("to_req", {31'd0, imem_req},    32'd0);
    chk("to_vld", {31'd0, instr_valid}, 32'd0);
    imem_ack = 1'b1;
    retire   = 1'b1;
    tick();
    tick();
    imem_ack = 1'b0;
    retire   = 1'b0;
    chk("err_sticky", {31'd0, fetch_err}, 32'd1);
    chk("err_req",    {31'd0, imem_req},  32'd0);

    // Reset out of S_ERR, then reset in the middle of a fetch with an ack
    rst_n = 1'b0;
    tick();
    chk("rst2_err", {31'd0, fetch_err}, 32'd0);
    chk("rst2_pc",  pc,                 32'h0);
    rst_n = 1'b1;
    tick();
    chk("rst2_req", {31'd0, imem_req}, 32'd1);
    rst_n      = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    chk("midrst_req",   {31'd0, imem_req},    32'd0);
    chk("midrst_pc",    pc,                   32'h0);
    chk("midrst_instr", instr,                32'd0);
    rst_n = 1'b1;
    tick();
    imem_ack = 1'b0;
    chk("late_ack_vld",   {31'd0, instr_valid}, 32'd0);
    chk("late_ack_instr", instr,                32'd0);
    chk("late_ack_req",   {31'd0, imem_req},    32'd1);
    fetch("post", 32'h0, 32'h1234_5678, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
